// File: rtl/rl_lut_addr_gen.sv
// Front-end of the range-limited LJ pipeline: turns a float r2 into a coefficient
// memory address/read enable and delays r2/valid/in-range to line up with memory q.
module rl_lut_addr_gen #(
    parameter int             DATA_WIDTH        = 32,
    parameter int             SEGMENT_NUM       = 14,
    parameter int             BIN_WIDTH         = 8,
    parameter int             LOOKUP_ADDR_WIDTH = 12,
    parameter logic [7:0]     EXP_0             = 8'd113,
    parameter int             LUT_LATENCY       = 1,
    parameter int             CNT_WIDTH         = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         r2_valid,
    input  logic [DATA_WIDTH-1:0]        r2,
    input  logic                         cnt_clr,
    output logic [LOOKUP_ADDR_WIDTH-1:0] lut_addr,
    output logic                         lut_rden,
    output logic [DATA_WIDTH-1:0]        r2_out,
    output logic                         r2_out_valid,
    output logic                         in_range_out,
    output logic [CNT_WIDTH-1:0]         oor_count
);

    localparam int SEG_W = LOOKUP_ADDR_WIDTH - BIN_WIDTH;

    logic                         sign;
    logic [7:0]                   e;
    logic [7:0]                   seg_full;
    logic                         in_range;
    logic                         oor_inc;
    logic [LOOKUP_ADDR_WIDTH-1:0] addr;

    always_comb begin
        sign     = r2[DATA_WIDTH-1];
        e        = r2[30:23];
        seg_full = e - EXP_0;
        // The upper-bound compare is done one bit wider so EXP_0 + SEGMENT_NUM cannot wrap.
        in_range = !sign && (e != 8'd0) && (e != 8'hFF) && (e >= EXP_0) &&
                   ({1'b0, e} < ({1'b0, EXP_0} + 9'(SEGMENT_NUM)));
        addr     = {seg_full[SEG_W-1:0], r2[22 -: BIN_WIDTH]};
        oor_inc  = r2_valid && !in_range;
    end

    logic                  s1_valid;
    logic                  s1_in_range;
    logic [DATA_WIDTH-1:0] s1_r2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lut_addr    <= '0;
            lut_rden    <= 1'b0;
            s1_valid    <= 1'b0;
            s1_in_range <= 1'b0;
            s1_r2       <= '0;
        end else begin
            lut_rden <= r2_valid && in_range;
            s1_valid <= r2_valid;
            if (r2_valid) begin
                lut_addr    <= in_range ? addr : '0;
                s1_in_range <= in_range;
                s1_r2       <= r2;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            oor_count <= '0;
        end else if (cnt_clr) begin
            oor_count <= CNT_WIDTH'(oor_inc);
        end else if (oor_inc && (oor_count != '1)) begin
            oor_count <= oor_count + 1'b1;
        end
    end

    // Data stages only load on a valid sample, so outputs hold across gaps.
    logic                  dl_valid    [LUT_LATENCY];
    logic                  dl_in_range [LUT_LATENCY];
    logic [DATA_WIDTH-1:0] dl_r2       [LUT_LATENCY];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LUT_LATENCY; i++) begin
                dl_valid[i]    <= 1'b0;
                dl_in_range[i] <= 1'b0;
                dl_r2[i]       <= '0;
            end
        end else begin
            dl_valid[0] <= s1_valid;
            if (s1_valid) begin
                dl_in_range[0] <= s1_in_range;
                dl_r2[0]       <= s1_r2;
            end
            for (int i = 1; i < LUT_LATENCY; i++) begin
                dl_valid[i] <= dl_valid[i-1];
                if (dl_valid[i-1]) begin
                    dl_in_range[i] <= dl_in_range[i-1];
                    dl_r2[i]       <= dl_r2[i-1];
                end
            end
        end
    end

    always_comb begin
        r2_out_valid = dl_valid[LUT_LATENCY-1];
        in_range_out = dl_in_range[LUT_LATENCY-1];
        r2_out       = dl_r2[LUT_LATENCY-1];
    end

endmodule

// File: tb/tb_rl_lut_addr_gen.sv
// Randomized scoreboard bench for rl_lut_addr_gen; a second instance with a
// 4-bit counter shares the stimulus to exercise counter saturation.
module tb_rl_lut_addr_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        r2_valid = 1'b0;
    logic [31:0] r2 = '0;
    logic        cnt_clr = 1'b0;

    logic [11:0] lut_addr, lut_addr4;
    logic        lut_rden, lut_rden4;
    logic [31:0] r2_out, r2_out4;
    logic        r2_out_valid, r2_out_valid4;
    logic        in_range_out, in_range_out4;
    logic [15:0] oor_count;
    logic [3:0]  oor_count4;

    rl_lut_addr_gen dut (
        .clk(clk), .rst(rst), .r2_valid(r2_valid), .r2(r2), .cnt_clr(cnt_clr),
        .lut_addr(lut_addr), .lut_rden(lut_rden), .r2_out(r2_out),
        .r2_out_valid(r2_out_valid), .in_range_out(in_range_out), .oor_count(oor_count)
    );

    rl_lut_addr_gen #(.CNT_WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .r2_valid(r2_valid), .r2(r2), .cnt_clr(cnt_clr),
        .lut_addr(lut_addr4), .lut_rden(lut_rden4), .r2_out(r2_out4),
        .r2_out_valid(r2_out_valid4), .in_range_out(in_range_out4), .oor_count(oor_count4)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic        rden;
        logic [11:0] addr;
        logic [15:0] c16;
        logic [3:0]  c4;
    } s1_t;

    typedef struct {
        int          due;
        logic [31:0] r2;
        logic        inr;
    } out_t;

    s1_t  sq[$];
    out_t oq[$];

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    logic [11:0] m_addr = '0;
    logic [15:0] m16 = '0;
    logic [3:0]  m4 = '0;
    logic [31:0] last_r2 = '0;
    logic        last_inr = 1'b0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference decode straight from the float fields with integer arithmetic.
    function automatic void ref_decode(input logic [31:0] v, output bit inr, output int addr);
        int e, m;
        e    = int'((v >> 23) & 32'hFF);
        m    = int'(v & 32'h7FFFFF);
        inr  = (v[31] == 1'b0) && (e >= 113) && (e < 113 + 14);
        addr = inr ? (e - 113) * 256 + m / 32768 : 0;
    endfunction

    function automatic logic [31:0] rand_r2();
        logic [31:0] specials [6];
        int k;
        specials = '{32'h0000_0000, 32'h7F80_0000, 32'h7FC0_0000, 32'h0000_1234,
                     32'h3F80_0000, 32'hFF80_0000};
        k = $urandom_range(0, 9);
        if (k <= 5) return {1'b0, 8'($urandom_range(111, 128)), 23'($urandom)};
        if (k == 6) return {1'b1, 8'($urandom_range(113, 126)), 23'($urandom)};
        if (k == 7) return specials[$urandom_range(0, 5)];
        if (k == 8) return $urandom;
        return ($urandom_range(0, 1) == 1) ? 32'h3F7F_FFFF : 32'h3880_0000;
    endfunction

    task automatic drive(input bit v, input logic [31:0] x, input bit clr);
        bit inr;
        int a;
        bit inc;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        r2_valid = v;
        r2       = x;
        cnt_clr  = clr;
        ref_decode(x, inr, a);
        inc = v && !inr;
        if (v) m_addr = 12'(a);
        if (clr) begin
            m16 = inc ? 16'd1 : 16'd0;
            m4  = inc ? 4'd1 : 4'd0;
        end else if (inc) begin
            if (m16 != 16'hFFFF) m16 = m16 + 16'd1;
            if (m4 != 4'hF) m4 = m4 + 4'd1;
        end
        sq.push_back('{cyc + 1, v && inr, m_addr, m16, m4});
        if (v) oq.push_back('{cyc + 2, x, inr});
    endtask

    task automatic apply_reset(input int n);
        @(posedge clk);
        #1;
        rst      = 1'b1;
        r2_valid = 1'b1;
        cnt_clr  = 1'b0;
        r2       = rand_r2();
        sq.delete();
        oq.delete();
        m_addr   = '0;
        m16      = '0;
        m4       = '0;
        last_r2  = '0;
        last_inr = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1 r2 = rand_r2();
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            chk("reset_ctrl", {lut_addr, lut_rden, r2_out_valid, in_range_out, oor_count}, '0);
            chk("reset_r2_out", r2_out, '0);
            chk("reset_cnt4", {28'd0, oor_count4}, '0);
        end else begin
            if (sq.size() > 0 && sq[0].due == cyc) begin
                s1_t s;
                s = sq.pop_front();
                chk("lut_rden", {31'd0, lut_rden}, {31'd0, s.rden});
                chk("lut_addr", {20'd0, lut_addr}, {20'd0, s.addr});
                chk("oor_count", {16'd0, oor_count}, {16'd0, s.c16});
                chk("oor_count_w4", {28'd0, oor_count4}, {28'd0, s.c4});
            end
            if (oq.size() > 0 && oq[0].due == cyc) begin
                out_t o;
                o = oq.pop_front();
                chk("r2_out_valid", {31'd0, r2_out_valid}, 32'd1);
                chk("r2_out", r2_out, o.r2);
                chk("in_range_out", {31'd0, in_range_out}, {31'd0, o.inr});
                last_r2  = o.r2;
                last_inr = o.inr;
            end else begin
                chk("r2_out_valid_idle", {31'd0, r2_out_valid}, 32'd0);
                chk("r2_out_hold", r2_out, last_r2);
                chk("in_range_hold", {31'd0, in_range_out}, {31'd0, last_inr});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] dir_in [4];
        logic [31:0] dir_oor [5];
        dir_in  = '{32'h3880_0000, 32'h38C0_0000, 32'h3F00_0000, 32'h3F7F_FFFF};
        dir_oor = '{32'h3F80_0000, 32'h3800_0000, 32'h0000_0000, 32'h7FC0_0000, 32'hBF00_0000};

        apply_reset(4);
        foreach (dir_in[i]) drive(1'b1, dir_in[i], 1'b0);
        foreach (dir_oor[i]) drive(1'b1, dir_oor[i], 1'b0);
        drive(1'b1, 32'h3880_0000, 1'b0);
        drive(1'b0, 32'hDEAD_BEEF, 1'b0);
        drive(1'b1, 32'h3F00_0000, 1'b0);
        repeat (3) drive(1'b0, 32'h3F00_0000, 1'b0);
        for (int i = 0; i < 20; i++) drive(1'b1, dir_oor[i % 5], 1'b0);
        drive(1'b1, 32'h3F80_0000, 1'b1);
        drive(1'b0, 32'h0, 1'b0);
        drive(1'b1, 32'h3F80_0000, 1'b0);
        drive(1'b0, 32'h0, 1'b1);

        for (int i = 0; i < 400; i++)
            drive($urandom_range(0, 4) != 0, rand_r2(), $urandom_range(0, 19) == 0);
        apply_reset(3);
        for (int i = 0; i < 200; i++)
            drive($urandom_range(0, 4) != 0, rand_r2(), $urandom_range(0, 19) == 0);

        repeat (4) drive(1'b0, 32'h0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("drain_out_queue", oq.size(), 0);
        chk("drain_s1_queue", sq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rl_lut_addr_gen.md
Name: rl_lut_addr_gen

Overview:
Front-end stage of the range-limited LJ force pipeline that drives the 1st-order interpolation coefficient memories (14 segments x 256 bins, 3584 words, 1-cycle read).
- Converts each incoming single-precision r2 into a segment/bin lookup address and a read enable for all coefficient memories in parallel.
- Delay-matches r2 and the valid/in-range status so they leave aligned with the memory q outputs for the downstream multiply-add stage.
- Counts out-of-range inputs for debug.

Parameters:
DATA_WIDTH, 32, float width (IEEE-754 single).
SEGMENT_NUM, 14, number of segments; each segment is twice as wide as the previous.
BIN_WIDTH, 8, log2 of bins per segment (256).
LOOKUP_ADDR_WIDTH, 12, memory address width.
EXP_0, 8'd113, biased exponent of segment 0 lower bound (2^-14).
LUT_LATENCY, 1, memory read latency in cycles; the delay line matches it.
CNT_WIDTH, 16, out-of-range counter width.

Ports:
clk  input  1  clock
rst  input  1  asynchronous, active-high reset
r2_valid  input  1  r2 sample valid
r2  input  DATA_WIDTH  squared distance, float
cnt_clr  input  1  synchronous clear of oor_count
lut_addr  output  LOOKUP_ADDR_WIDTH  address to all coefficient memories
lut_rden  output  1  read enable to all coefficient memories
r2_out  output  DATA_WIDTH  r2 aligned with memory q
r2_out_valid  output  1  aligned valid; high even when out of range
in_range_out  output  1  aligned flag; 0 means force must be zeroed
oor_count  output  CNT_WIDTH  saturating out-of-range count

Behaviour:
- Single clock; the only reset is asynchronous active-high rst.
- All outputs, the delay line and the counter reset to 0.
- Streaming, no backpressure. One sample is accepted per cycle whenever r2_valid=1.
- Decode, done combinationally on the input and registered at the cycle T+1 edge:
  - e = r2[30:23]
  - seg = e - EXP_0 (4 bits)
  - bin = r2[22:23-BIN_WIDTH]
  - addr = seg*256 + bin = {seg, bin}
- In range iff all of the following hold:
  - sign = 0
  - e != 0 (this also excludes zero and denormals)
  - e != 255 (excludes Inf/NaN)
  - EXP_0 <= e < EXP_0 + SEGMENT_NUM
- Stage 1 (register at T+1):
  - lut_addr <= addr if in range, else 0.
  - lut_rden <= r2_valid & in_range.
  - lut_addr holds its last value when r2_valid=0.
- Delay line: r2, valid and in_range are delayed 1 + LUT_LATENCY cycles. r2_out, r2_out_valid and in_range_out change at the edge that opens cycle T+1+LUT_LATENCY (T+2 by default), the same cycle q is valid.
- r2_out and in_range_out hold their previous values when r2_out_valid=0.
- oor_count:
  - Increments by 1 on each accepted out-of-range sample (counted at stage 1).
  - Saturates at all-ones.
  - When cnt_clr and an increment coincide in the same cycle, the result is 1.
  - cnt_clr alone gives 0.
- Back-to-back samples give back-to-back outputs; there are no bubbles and no reordering.
- rst asserted mid-stream: all in-flight samples are discarded immediately. No r2_out_valid is produced for them after rst is released.
- Boundaries:
  - e = EXP_0 + SEGMENT_NUM - 1 with mantissa all ones maps to addr 3583.
  - e = EXP_0 with mantissa 0 maps to addr 0.
  - Any address >= SEGMENT_NUM*256 is never issued.

Test Plan:
- Reset: assert rst with r2_valid=1 streaming -> all outputs 0; release rst -> first r2_out_valid appears exactly 2 cycles after the first sample accepted post-reset.
- r2=0x38800000 (2^-14) at T -> lut_addr=0, lut_rden=1 at T+1; r2_out=0x38800000, r2_out_valid=1, in_range_out=1 at T+2.
- r2=0x38C00000 -> addr 128. r2=0x3F000000 (0.5) -> addr 3328. r2=0x3F7FFFFF -> addr 3583. Streamed back-to-back, the outputs are consecutive and in order.
- Out of range: 0x3F800000 (1.0), 0x38000000, 0x00000000, 0x7FC00000 (NaN), 0xBF000000 (negative) -> lut_rden=0 and lut_addr=0 each cycle, r2_out_valid=1 with in_range_out=0, oor_count=5.
- Counter: preload near saturation with CNT_WIDTH=4 and drive 20 out-of-range samples -> holds 15. Pulse cnt_clr together with an out-of-range sample -> 1. Pulse cnt_clr alone -> 0.
- Gaps: r2_valid pattern 1,0,1 -> lut_rden pattern 1,0,1 one cycle later; r2_out_valid pattern 1,0,1 two cycles later; lut_addr and r2_out held during the gap.
